// File: rtl/seq_alu_if.sv
// Operand/result bus of the sequential ALU: the start/done handshake, the operands,
// the registered result and the compare flags.
interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic                 mode;
   logic [2:0]           opcode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   out_alu;
   logic                 za;
   logic                 zb;
   logic                 eq;
   logic                 gt;
   logic                 lt;
   logic                 dz;

   modport master (
      output start, mode, opcode, a, b,
      input  busy, done, out_alu, za, zb, eq, gt, lt, dz
   );

   modport slave (
      input  start, mode, opcode, a, b,
      output busy, done, out_alu, za, zb, eq, gt, lt, dz
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU with a start/done handshake. Multiply (shift-add) and divide (restoring) are iterative.
// Define SEQ_ALU_SIGNED_CMP_EN to make the gt/lt flags compare signed.
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   typedef struct packed {
      logic za;
      logic zb;
      logic eq;
      logic gt;
      logic lt;
   } flags_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_mode;
   logic [2:0]         r_op;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_out;
   flags_t             r_flags;
   logic               r_dz;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic               w_mode;
   logic [2:0]         w_op;
   logic               w_iter_op;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_logic;
   logic [2*WIDTH-1:0] w_single;
   flags_t             w_flags;
   logic [WIDTH:0]     w_mul_add;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic               w_is_mul;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_iter_result;

   assign w_accept = (r_state == S_IDLE) && bus.start;
   assign w_last   = (r_state == S_CALC) && (r_cnt == LAST_ITER);

   // In IDLE the operands are taken straight from the bus so single-cycle results land on the accepting edge.
   assign w_a    = (r_state == S_IDLE) ? bus.a      : r_a;
   assign w_b    = (r_state == S_IDLE) ? bus.b      : r_b;
   assign w_mode = (r_state == S_IDLE) ? bus.mode   : r_mode;
   assign w_op   = (r_state == S_IDLE) ? bus.opcode : r_op;

   assign w_iter_op = w_mode && ((w_op == 3'b001) || ((w_op == 3'b010) && !(w_a > w_b)));

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves the signal unassigned (no latch).
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_next = w_iter_op ? S_CALC : S_FIN;
         S_CALC:  if (r_cnt == LAST_ITER) w_state_next = S_FIN;
         S_FIN:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_sum = {1'b0, w_a} + {1'b0, w_b};

   always_comb begin
      w_logic = '0;
      case (w_op)
         3'b000:  w_logic = w_a & w_b;
         3'b001:  w_logic = w_a | w_b;
         3'b010:  w_logic = ~(w_a | w_b);
         3'b011:  w_logic = w_a ^ w_b;
         3'b100:  w_logic = ~w_a;
         3'b101:  w_logic = ~w_b;
         3'b110:  w_logic = ~(w_a ^ w_b);
         default: w_logic = '0;
      endcase
   end

   always_comb begin
      w_single = '0;
      if (w_mode) begin
         case (w_op)
            3'b000:  w_single = {{(WIDTH-1){1'b0}}, w_sum};
            3'b010:  w_single = {{WIDTH{1'b0}}, w_a - w_b};
            3'b011:  w_single = {{WIDTH{1'b0}}, w_a} - {{WIDTH{1'b0}}, w_b};
            default: w_single = '0;
         endcase
      end else begin
         w_single = {{WIDTH{1'b0}}, w_logic};
      end
   end

   always_comb begin
      w_flags.za = (w_a == '0);
      w_flags.zb = (w_b == '0);
      w_flags.eq = (w_a == w_b);
`ifdef SEQ_ALU_SIGNED_CMP_EN
      w_flags.gt = ($signed(w_a) > $signed(w_b));
`else
      w_flags.gt = (w_a > w_b);
`endif
      w_flags.lt = !w_flags.eq && !w_flags.gt;
   end

   // Multiply: acc = {partial product, multiplier}, add A on bit 0 then shift right.
   assign w_mul_add = r_acc[0] ? {1'b0, r_a} : '0;
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_mul_add;

   // Divide B/A: acc = {remainder, quotient}, shift left and try subtracting A.
   assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_diff  = w_div_shift - {1'b0, r_a};

   assign w_is_mul   = (r_op == 3'b001);
   assign w_acc_next = w_is_mul ? {w_mul_sum, r_acc[WIDTH-1:1]}
                     : (w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1});

   assign w_iter_result = w_is_mul ? w_acc_next
                        : ((r_a == '0) ? '0 : {{WIDTH{1'b0}}, w_acc_next[WIDTH-1:0]});

   // NOTE: operand latches and accumulator carry no reset; each is written before it is read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a    <= bus.a;
         r_b    <= bus.b;
         r_mode <= bus.mode;
         r_op   <= bus.opcode;
         r_acc  <= {{WIDTH{1'b0}}, bus.b};
      end else if (r_state == S_CALC) begin
         r_acc  <= w_acc_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_out   <= '0;
         r_flags <= '0;
         r_dz    <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         if (!w_iter_op) begin
            r_out   <= w_single;
            r_flags <= w_flags;
            r_dz    <= 1'b0;
         end
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_out   <= w_iter_result;
            r_flags <= w_flags;
            r_dz    <= !w_is_mul && (r_a == '0);
         end
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = (r_state == S_FIN);
   assign bus.out_alu = r_out;
   assign bus.za      = r_flags.za;
   assign bus.zb      = r_flags.zb;
   assign bus.eq      = r_flags.eq;
   assign bus.gt      = r_flags.gt;
   assign bus.lt      = r_flags.lt;
   assign bus.dz      = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16); expected values are hand-computed.
// Flags are compared as {za, zb, eq, gt, lt, dz}.
module tb_seq_alu;

   localparam int W = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] flags();
      return {bus.za, bus.zb, bus.eq, bus.gt, bus.lt, bus.dz};
   endfunction

   // Issue one op, scramble the inputs after acceptance, then check latency, busy, result and hold.
   task automatic do_op(input string tag, input logic mode, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_out, input logic [5:0] exp_flags,
                        input int exp_lat);
      int lat;
      int busy_n;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mode   = mode;
      bus.opcode = op;
      bus.a      = a;
      bus.b      = b;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.mode   = ~mode;
      bus.opcode = op ^ 3'b101;
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      lat    = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_n++;
      end while (!bus.done && lat < 100);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy"}, 64'(busy_n), 64'(exp_lat));
      check({tag, " out"}, 64'(bus.out_alu), 64'(exp_out));
      check({tag, " flags"}, 64'(flags()), 64'(exp_flags));
      @(negedge clk);
      check({tag, " done pulse"}, 64'({bus.done, bus.busy}), 64'(0));
      check({tag, " hold"}, 64'(bus.out_alu), 64'(exp_out));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int gap;
      int dones;
      logic [5:0] big_flags;
      logic [2*W-1:0] logic_exp [8];

      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.mode   = 1'b0;
      bus.opcode = 3'b000;
      bus.a      = '0;
      bus.b      = '0;
      repeat (2) @(negedge clk);
      check("reset state", 64'({bus.busy, bus.done, bus.out_alu, flags()}), 64'(0));
      rst = 1'b0;

      do_op("mul ffff*ffff", 1'b1, 3'b001, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 6'b001000, W + 1);
      do_op("div 100/7", 1'b1, 3'b010, 16'd7, 16'd100, 32'd14, 6'b000010, W + 1);
      do_op("div by zero", 1'b1, 3'b010, 16'd0, 16'd5, 32'd0, 6'b100011, W + 1);
      do_op("sub a>b", 1'b1, 3'b010, 16'd9, 16'd4, 32'd5, 6'b000100, 1);
      do_op("sub signext", 1'b1, 3'b011, 16'd3, 16'd5, 32'hFFFFFFFE, 6'b000010, 1);
      do_op("arith op101", 1'b1, 3'b101, 16'd5, 16'd5, 32'd0, 6'b001000, 1);
      do_op("add carry", 1'b1, 3'b000, 16'h8001, 16'h8000, 32'h00010001, 6'b000100, 1);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mode   = 1'b1;
      bus.opcode = 3'b001;
      bus.a      = 16'h1234;
      bus.b      = 16'h5678;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async reset", 64'({bus.busy, bus.done, bus.out_alu, flags()}), 64'(0));
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      check("no done after abort", 64'(dones), 64'(0));
      do_op("mul after reset", 1'b1, 3'b001, 16'd3, 16'd4, 32'd12, 6'b000010, W + 1);

      logic_exp[0] = 32'h0000_0000;
      logic_exp[1] = 32'h0000_0FFF;
      logic_exp[2] = 32'h0000_F000;
      logic_exp[3] = 32'h0000_0FFF;
      logic_exp[4] = 32'h0000_FF0F;
      logic_exp[5] = 32'h0000_F0F0;
      logic_exp[6] = 32'h0000_F000;
      logic_exp[7] = 32'h0000_0000;
      for (int i = 0; i < 8; i++)
         do_op($sformatf("logic op%0d", i), 1'b0, 3'(i), 16'h00F0, 16'h0F0F,
               logic_exp[i], 6'b000010, 1);

      // Start held high: the second multiply is only accepted in the IDLE cycle after done.
`ifdef SEQ_ALU_SIGNED_CMP_EN
      big_flags = 6'b000010;
`else
      big_flags = 6'b000100;
`endif
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mode   = 1'b1;
      bus.opcode = 3'b001;
      bus.a      = 16'h8000;
      bus.b      = 16'h0001;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.done && lat < 100);
      check("held start first latency", 64'(lat), 64'(W + 1));
      check("held start first out", 64'(bus.out_alu), 64'(32'h0000_8000));
      check("held start flags", 64'(flags()), 64'(big_flags));
      @(negedge clk);
      check("held start idle gap", 64'(bus.busy), 64'(0));
      gap = 1;
      do begin
         @(negedge clk);
         gap++;
      end while (!bus.done && gap < 100);
      bus.start = 1'b0;
      check("held start second gap", 64'(gap), 64'(W + 2));
      check("held start second out", 64'(bus.out_alu), 64'(32'h0000_8000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
